// File: rtl/regfile_issue_stage_pkg.sv
// regfile_issue_stage_pkg
//   RV32 ISA constants shared by the issue stage: opcode values, the
//   instruction field layout, register index width and helper functions.
//   Build option: RF_BYPASS_EN (when defined, a writeback landing in the
//   accept cycle is forwarded to the operands and clears the source hazard).
package regfile_issue_stage_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // Field bit positions inside a 32-bit instruction word.
  localparam int OPCODE_LSB = 0;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int FUNCT7_LSB = 25;

`ifdef RF_BYPASS_EN
  localparam logic BYPASS_EN = 1'b1;
`else
  localparam logic BYPASS_EN = 1'b0;
`endif

  // MSB-first so a plain cast of the instruction word lines up with the fields above.
  typedef struct packed {
    logic [6:0]           funct7;
    logic [REG_IDX_W-1:0] rs2;
    logic [REG_IDX_W-1:0] rs1;
    logic [2:0]           funct3;
    logic [REG_IDX_W-1:0] rd;
    logic [6:0]           opcode;
  } instr_fields_t;

  // Stores and branches carry immediate bits in the rd slot.
  function automatic logic writes_rd(input logic [6:0] opcode);
    logic w;
    case (opcode)
      OP_STORE, OP_BRANCH: w = 1'b0;
      default:             w = 1'b1;
    endcase
    return w;
  endfunction

  // x0 and indices beyond the implemented file never hold state.
  function automatic logic idx_ok(input logic [REG_IDX_W-1:0] idx, input int nregs);
    return (idx != 5'd0) && (int'({27'd0, idx}) < nregs);
  endfunction

endpackage

// File: rtl/regfile_issue_stage_if.sv
// regfile_issue_stage_if
//   Bundles the fetch-side instruction handshake, the ALU-side issue bundle,
//   the writeback port and the stall counter of the issue stage.
//   master: environment (fetch, ALU, writeback driver)
//   slave : the issue stage
interface regfile_issue_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic              dec_valid;
  logic              dec_ready;
  logic [6:0]        dec_opcode;
  logic [4:0]        dec_rd;
  logic [2:0]        dec_funct3;
  logic [6:0]        dec_funct7;
  logic [11:0]       dec_imm;
  logic [XLEN-1:0]   dec_rs1_data;
  logic [XLEN-1:0]   dec_rs2_data;
  logic              wb_en;
  logic [4:0]        wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output instr_valid, instr, dec_ready, wb_en, wb_addr, wb_data,
    input  instr_ready, dec_valid, dec_opcode, dec_rd, dec_funct3, dec_funct7,
           dec_imm, dec_rs1_data, dec_rs2_data, stall_cnt
  );

  modport slave (
    input  instr_valid, instr, dec_ready, wb_en, wb_addr, wb_data,
    output instr_ready, dec_valid, dec_opcode, dec_rd, dec_funct3, dec_funct7,
           dec_imm, dec_rs1_data, dec_rs2_data, stall_cnt
  );
endinterface

// File: rtl/regfile_issue_stage_scoreboard.sv
// regfile_issue_stage_scoreboard
//   Pending-write tracker. One busy bit per architectural register, set when
//   a writing instruction issues and cleared by its writeback.
//   Ports: clk, rst (sync, active-high), rs1/rs2/rd + rd_write of the offered
//   instruction, set_en (instruction accepted), wb_en/wb_addr, hazard out.
//   Build option: RF_BYPASS_EN lets a same-cycle writeback clear a source hazard.
module regfile_issue_stage_scoreboard
  import regfile_issue_stage_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic [REG_IDX_W-1:0] rd,
  input  logic                 rd_write,
  input  logic                 set_en,
  input  logic                 wb_en,
  input  logic [REG_IDX_W-1:0] wb_addr,
  output logic                 hazard
);
  localparam int RIDX_W = $clog2(NREGS);

  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] set_mask_s;
  logic [NREGS-1:0] clr_mask_s;
  logic             rs1_busy_s;
  logic             rs2_busy_s;
  logic             rd_busy_s;

  function automatic logic busy_of(input logic [NREGS-1:0] vec,
                                   input logic [REG_IDX_W-1:0] idx);
    logic b;
    b = 1'b0;
    if (idx_ok(idx, NREGS)) begin
      b = vec[idx[RIDX_W-1:0]];
    end else begin
      b = 1'b0;
    end
    return b;
  endfunction

  // One-hot set/clear masks for this edge.
  always_comb begin
    set_mask_s = '0;
    clr_mask_s = '0;
    if (set_en && rd_write && idx_ok(rd, NREGS)) begin
      set_mask_s[rd[RIDX_W-1:0]] = 1'b1;
    end else begin
      set_mask_s = '0;
    end
    if (wb_en && idx_ok(wb_addr, NREGS)) begin
      clr_mask_s[wb_addr[RIDX_W-1:0]] = 1'b1;
    end else begin
      clr_mask_s = '0;
    end
  end

  // Busy vector; set is applied after clear so a same-edge set wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= '0;
    end else begin
      busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
    end
  end

  // RAW on either source, WAW on the destination.
  always_comb begin
    rs1_busy_s = busy_of(busy_r, rs1) & ~(BYPASS_EN & wb_en & (wb_addr == rs1));
    rs2_busy_s = busy_of(busy_r, rs2) & ~(BYPASS_EN & wb_en & (wb_addr == rs2));
    rd_busy_s  = rd_write & busy_of(busy_r, rd);
    hazard     = rs1_busy_s | rs2_busy_s | rd_busy_s;
  end

endmodule

// File: rtl/regfile_issue_stage.sv
// regfile_issue_stage
//   Integer register file plus RV32 decode/issue register. Accepts an
//   instruction when the issue register is free (or draining) and no hazard
//   exists, and presents the decoded bundle with operands one cycle later.
//   Ports: clk, rst (sync, active-high), bus (regfile_issue_stage_if.slave:
//   instr handshake, dec_* bundle handshake, wb_* writeback, stall_cnt).
//   Build option: RF_BYPASS_EN forwards a same-cycle writeback to the operands.
module regfile_issue_stage
  import regfile_issue_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  regfile_issue_stage_if.slave bus
);
  localparam int RIDX_W = $clog2(NREGS);

  instr_fields_t    f_s;
  logic [XLEN-1:0]  reg_r [NREGS];
  logic             hazard_s;
  logic             wr_rd_s;
  logic             instr_ready_s;
  logic             accept_s;
  logic [XLEN-1:0]  rs1_data_s;
  logic [XLEN-1:0]  rs2_data_s;
  logic             wb_hit1_s;
  logic             wb_hit2_s;

  logic             dec_valid_r;
  logic [6:0]       dec_opcode_r;
  logic [4:0]       dec_rd_r;
  logic [2:0]       dec_funct3_r;
  logic [6:0]       dec_funct7_r;
  logic [11:0]      dec_imm_r;
  logic [XLEN-1:0]  dec_rs1_data_r;
  logic [XLEN-1:0]  dec_rs2_data_r;
  logic [CNT_W-1:0] stall_cnt_r;

  assign f_s           = instr_fields_t'(bus.instr);
  assign wr_rd_s       = writes_rd(f_s.opcode);
  assign instr_ready_s = (!dec_valid_r || bus.dec_ready) && !hazard_s;
  assign accept_s      = bus.instr_valid && instr_ready_s;

  regfile_issue_stage_scoreboard #(.NREGS(NREGS)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .rs1      (f_s.rs1),
    .rs2      (f_s.rs2),
    .rd       (f_s.rd),
    .rd_write (wr_rd_s),
    .set_en   (accept_s),
    .wb_en    (bus.wb_en),
    .wb_addr  (bus.wb_addr),
    .hazard   (hazard_s)
  );

  // Operand read: forwarded writeback first (bypass builds), then the array; x0/out-of-range read 0.
  always_comb begin
    wb_hit1_s  = BYPASS_EN && bus.wb_en && idx_ok(bus.wb_addr, NREGS) && (bus.wb_addr == f_s.rs1);
    wb_hit2_s  = BYPASS_EN && bus.wb_en && idx_ok(bus.wb_addr, NREGS) && (bus.wb_addr == f_s.rs2);
    rs1_data_s = '0;
    rs2_data_s = '0;
    if (wb_hit1_s) begin
      rs1_data_s = bus.wb_data;
    end else if (idx_ok(f_s.rs1, NREGS)) begin
      rs1_data_s = reg_r[f_s.rs1[RIDX_W-1:0]];
    end else begin
      rs1_data_s = '0;
    end
    if (wb_hit2_s) begin
      rs2_data_s = bus.wb_data;
    end else if (idx_ok(f_s.rs2, NREGS)) begin
      rs2_data_s = reg_r[f_s.rs2[RIDX_W-1:0]];
    end else begin
      rs2_data_s = '0;
    end
  end

  // Register array write port; x0 and out-of-range writebacks are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        reg_r[i] <= '0;
      end
    end else if (bus.wb_en && idx_ok(bus.wb_addr, NREGS)) begin
      reg_r[bus.wb_addr[RIDX_W-1:0]] <= bus.wb_data;
    end
  end

  // Issue register: load on accept, hold while stalled downstream, empty after handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_valid_r    <= 1'b0;
      dec_opcode_r   <= 7'd0;
      dec_rd_r       <= 5'd0;
      dec_funct3_r   <= 3'd0;
      dec_funct7_r   <= 7'd0;
      dec_imm_r      <= 12'd0;
      dec_rs1_data_r <= '0;
      dec_rs2_data_r <= '0;
    end else if (accept_s) begin
      dec_valid_r    <= 1'b1;
      dec_opcode_r   <= f_s.opcode;
      dec_rd_r       <= f_s.rd;
      dec_funct3_r   <= f_s.funct3;
      dec_funct7_r   <= f_s.funct7;
      dec_imm_r      <= {f_s.funct7, f_s.rs2};
      dec_rs1_data_r <= rs1_data_s;
      dec_rs2_data_r <= rs2_data_s;
    end else if (bus.dec_ready) begin
      dec_valid_r    <= 1'b0;
    end
  end

  // Saturating count of cycles an offered instruction was refused.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= '0;
    end else if (bus.instr_valid && !instr_ready_s && (stall_cnt_r != '1)) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1);
    end
  end

  assign bus.instr_ready  = instr_ready_s;
  assign bus.dec_valid    = dec_valid_r;
  assign bus.dec_opcode   = dec_opcode_r;
  assign bus.dec_rd       = dec_rd_r;
  assign bus.dec_funct3   = dec_funct3_r;
  assign bus.dec_funct7   = dec_funct7_r;
  assign bus.dec_imm      = dec_imm_r;
  assign bus.dec_rs1_data = dec_rs1_data_r;
  assign bus.dec_rs2_data = dec_rs2_data_r;
  assign bus.stall_cnt    = stall_cnt_r;

endmodule

// File: tb/tb_regfile_issue_stage.sv
// tb_regfile_issue_stage
//   Directed bench for regfile_issue_stage. Two instances: a (NREGS=32) and
//   b (NREGS=16). Expected bundles are pushed into per-instance queues when
//   an instruction is offered for acceptance; monitors pop and compare on
//   every dec_valid/dec_ready handshake. Build option: RF_BYPASS_EN.
module tb_regfile_issue_stage;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] imm;
    logic [31:0] rs1;
    logic [31:0] rs2;
  } exp_t;

`ifdef RF_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  exp_t qa[$];
  exp_t qb[$];

  regfile_issue_stage_if #(.XLEN(32), .CNT_W(16)) ia ();
  regfile_issue_stage_if #(.XLEN(32), .CNT_W(16)) ib ();

  regfile_issue_stage #(.XLEN(32), .NREGS(32), .CNT_W(16)) u_dut_a (
    .clk (clk), .rst (rst), .bus (ia)
  );
  regfile_issue_stage #(.XLEN(32), .NREGS(16), .CNT_W(16)) u_dut_b (
    .clk (clk), .rst (rst), .bus (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [6:0] op, input logic [4:0] rd,
                              input logic [2:0] f3, input logic [6:0] f7,
                              input logic [11:0] imm, input logic [31:0] r1,
                              input logic [31:0] r2);
    exp_t e;
    e = '{opcode: op, rd: rd, funct3: f3, funct7: f7, imm: imm, rs1: r1, rs2: r2};
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Monitor for instance a: compare every accepted bundle with the queue head.
  always @(negedge clk) begin
    exp_t got;
    exp_t want;
    if (!rst && ia.dec_valid && ia.dec_ready) begin
      got = mk(ia.dec_opcode, ia.dec_rd, ia.dec_funct3, ia.dec_funct7,
               ia.dec_imm, ia.dec_rs1_data, ia.dec_rs2_data);
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_bundle_unexpected actual=%h", got);
      end else begin
        want = qa.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL a_bundle actual op=%h rd=%h f3=%h f7=%h imm=%h rs1=%h rs2=%h required op=%h rd=%h f3=%h f7=%h imm=%h rs1=%h rs2=%h",
                   got.opcode, got.rd, got.funct3, got.funct7, got.imm, got.rs1, got.rs2,
                   want.opcode, want.rd, want.funct3, want.funct7, want.imm, want.rs1, want.rs2);
        end
      end
    end
  end

  // Monitor for instance b.
  always @(negedge clk) begin
    exp_t got;
    exp_t want;
    if (!rst && ib.dec_valid && ib.dec_ready) begin
      got = mk(ib.dec_opcode, ib.dec_rd, ib.dec_funct3, ib.dec_funct7,
               ib.dec_imm, ib.dec_rs1_data, ib.dec_rs2_data);
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_bundle_unexpected actual=%h", got);
      end else begin
        want = qb.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL b_bundle actual op=%h rd=%h f3=%h f7=%h imm=%h rs1=%h rs2=%h required op=%h rd=%h f3=%h f7=%h imm=%h rs1=%h rs2=%h",
                   got.opcode, got.rd, got.funct3, got.funct7, got.imm, got.rs1, got.rs2,
                   want.opcode, want.rd, want.funct3, want.funct7, want.imm, want.rs1, want.rs2);
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    ia.instr_valid = 1'b0; ia.instr = 32'd0; ia.dec_ready = 1'b1;
    ia.wb_en = 1'b0; ia.wb_addr = 5'd0; ia.wb_data = 32'd0;
    ib.instr_valid = 1'b0; ib.instr = 32'd0; ib.dec_ready = 1'b1;
    ib.wb_en = 1'b0; ib.wb_addr = 5'd0; ib.wb_data = 32'd0;
    repeat (3) pos();
    rst = 1'b0;

    // Reset state.
    neg();
    chk("a_reset_dec_valid", 64'(ia.dec_valid), 64'd0);
    chk("a_reset_stall_cnt", 64'(ia.stall_cnt), 64'd0);
    chk("a_reset_instr_ready", 64'(ia.instr_ready), 64'd1);
    chk("a_reset_dec_opcode", 64'(ia.dec_opcode), 64'd0);
    chk("a_reset_dec_rs1", 64'(ia.dec_rs1_data), 64'd0);
    chk("b_reset_dec_valid", 64'(ib.dec_valid), 64'd0);
    pos();

    // add x3,x1,x2 on a fresh file.
    ia.instr = 32'h002081B3; ia.instr_valid = 1'b1;
    qa.push_back(mk(7'h33, 5'd3, 3'd0, 7'h00, 12'h002, 32'h0, 32'h0));
    neg(); chk("a_add_ready", 64'(ia.instr_ready), 64'd1);
    pos(); ia.instr_valid = 1'b0;

    // wb x1=5 then addi x6,x1,0.
    ia.wb_en = 1'b1; ia.wb_addr = 5'd1; ia.wb_data = 32'h5;
    neg(); pos(); ia.wb_en = 1'b0;
    ia.instr = 32'h00008313; ia.instr_valid = 1'b1;
    qa.push_back(mk(7'h13, 5'd6, 3'd0, 7'h00, 12'h000, 32'h5, 32'h0));
    neg(); chk("a_addi_ready", 64'(ia.instr_ready), 64'd1);
    pos(); ia.instr_valid = 1'b0;

    // wb x0 is ignored: add x7,x0,x1.
    ia.wb_en = 1'b1; ia.wb_addr = 5'd0; ia.wb_data = 32'hFFFF;
    neg(); pos(); ia.wb_en = 1'b0;
    ia.instr = 32'h001003B3; ia.instr_valid = 1'b1;
    qa.push_back(mk(7'h33, 5'd7, 3'd0, 7'h00, 12'h001, 32'h0, 32'h5));
    neg(); chk("a_x0_ready", 64'(ia.instr_ready), 64'd1);
    pos(); ia.instr_valid = 1'b0;

    // sub x4,x3,x1 stalls on busy x3 for four cycles.
    ia.instr = 32'h40118233; ia.instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      neg(); chk("a_raw_stall_ready", 64'(ia.instr_ready), 64'd0);
      pos();
    end
    ia.instr_valid = 1'b0;
    ia.wb_en = 1'b1; ia.wb_addr = 5'd3; ia.wb_data = 32'hA5A50003;
    neg(); chk("a_stall_cnt4", 64'(ia.stall_cnt), 64'd4);
    pos(); ia.wb_en = 1'b0;
    ia.instr_valid = 1'b1;
    qa.push_back(mk(7'h33, 5'd4, 3'd0, 7'h20, 12'h401, 32'hA5A50003, 32'h5));
    neg(); chk("a_after_wb_ready", 64'(ia.instr_ready), 64'd1);
    pos(); ia.instr_valid = 1'b0;

    // add x8,x6,x0 with wb x6 in the same cycle.
    ia.instr = 32'h00030433; ia.instr_valid = 1'b1;
    ia.wb_en = 1'b1; ia.wb_addr = 5'd6; ia.wb_data = 32'h12345678;
    qa.push_back(mk(7'h33, 5'd8, 3'd0, 7'h00, 12'h000, 32'h12345678, 32'h0));
    neg(); chk("a_samecycle_ready", 64'(ia.instr_ready), 64'(BYP));
    pos(); ia.wb_en = 1'b0;
`ifndef RF_BYPASS_EN
    neg(); chk("a_nextcycle_ready", 64'(ia.instr_ready), 64'd1);
    pos();
`endif
    ia.instr_valid = 1'b0;
    neg(); chk("a_stall_cnt_bypass", 64'(ia.stall_cnt), BYP ? 64'd4 : 64'd5);
    pos();

    // WAW: addi x4 while x4 busy; store with rd-field 4 is not a writer.
    ia.instr = 32'h00208213;
    neg(); chk("a_waw_ready", 64'(ia.instr_ready), 64'd0);
    pos();
    ia.instr = 32'h00208223; ia.instr_valid = 1'b1;
    qa.push_back(mk(7'h23, 5'd4, 3'd0, 7'h00, 12'h002, 32'h5, 32'h0));
    neg(); chk("a_store_ready", 64'(ia.instr_ready), 64'd1);
    pos(); ia.instr_valid = 1'b0;
    neg(); pos();

    // Downstream back-pressure: bundle held stable for three cycles.
    ia.dec_ready = 1'b0;
    ia.instr = 32'h00208493; ia.instr_valid = 1'b1;
    qa.push_back(mk(7'h13, 5'd9, 3'd0, 7'h00, 12'h002, 32'h5, 32'h0));
    neg(); chk("a_hold_first_ready", 64'(ia.instr_ready), 64'd1);
    pos();
    ia.instr = 32'h00108513;
    qa.push_back(mk(7'h13, 5'd10, 3'd0, 7'h00, 12'h001, 32'h5, 32'h5));
    for (int i = 0; i < 3; i++) begin
      neg();
      chk("a_hold_valid", 64'(ia.dec_valid), 64'd1);
      chk("a_hold_rd", 64'(ia.dec_rd), 64'd9);
      chk("a_hold_rs1", 64'(ia.dec_rs1_data), 64'h5);
      chk("a_hold_ready", 64'(ia.instr_ready), 64'd0);
      pos();
    end
    ia.dec_ready = 1'b1;
    neg(); chk("a_release_ready", 64'(ia.instr_ready), 64'd1);
    pos(); ia.instr_valid = 1'b0;
    neg(); chk("a_stall_cnt_hold", 64'(ia.stall_cnt), BYP ? 64'd7 : 64'd8);
    pos();

    // NREGS=16: wb x20 ignored (no alias onto x4), rs1=20 reads 0.
    ib.wb_en = 1'b1; ib.wb_addr = 5'd20; ib.wb_data = 32'hDEAD;
    neg(); pos(); ib.wb_en = 1'b0;
    ib.instr = 32'h000A0293; ib.instr_valid = 1'b1;
    qb.push_back(mk(7'h13, 5'd5, 3'd0, 7'h00, 12'h000, 32'h0, 32'h0));
    neg(); chk("b_rs20_ready", 64'(ib.instr_ready), 64'd1);
    pos();
    ib.instr = 32'h00020313;
    qb.push_back(mk(7'h13, 5'd6, 3'd0, 7'h00, 12'h000, 32'h0, 32'h0));
    neg(); pos(); ib.instr_valid = 1'b0;

    // rd=20 sets no busy bit (x4 must stay free).
    ib.instr = 32'h00008A13; ib.instr_valid = 1'b1;
    qb.push_back(mk(7'h13, 5'd20, 3'd0, 7'h00, 12'h000, 32'h0, 32'h0));
    neg(); chk("b_rd20_ready", 64'(ib.instr_ready), 64'd1);
    pos(); ib.instr_valid = 1'b0;
    ib.instr = 32'h00020593;
    neg(); chk("b_x4_not_busy", 64'(ib.instr_ready), 64'd1);
    pos();

    // Reset in the middle of a RAW stall.
    ib.wb_en = 1'b1; ib.wb_addr = 5'd1; ib.wb_data = 32'h77;
    neg(); pos(); ib.wb_en = 1'b0;
    ib.instr = 32'h002081B3; ib.instr_valid = 1'b1;
    qb.push_back(mk(7'h33, 5'd3, 3'd0, 7'h00, 12'h002, 32'h77, 32'h0));
    neg(); chk("b_add_ready", 64'(ib.instr_ready), 64'd1);
    pos();
    ib.instr = 32'h40118233;
    for (int i = 0; i < 2; i++) begin
      neg(); chk("b_raw_stall_ready", 64'(ib.instr_ready), 64'd0);
      pos();
    end
    neg(); chk("b_stall_cnt2", 64'(ib.stall_cnt), 64'd2);
    pos();
    ib.instr_valid = 1'b0; rst = 1'b1;
    pos(); rst = 1'b0;
    neg();
    chk("b_rst_dec_valid", 64'(ib.dec_valid), 64'd0);
    chk("b_rst_stall_cnt", 64'(ib.stall_cnt), 64'd0);
    chk("a_rst_stall_cnt", 64'(ia.stall_cnt), 64'd0);
    chk("b_rst_busy_clear", 64'(ib.instr_ready), 64'd1);
    pos();
    ib.instr_valid = 1'b1;
    qb.push_back(mk(7'h33, 5'd4, 3'd0, 7'h20, 12'h401, 32'h0, 32'h0));
    neg(); chk("b_post_rst_ready", 64'(ib.instr_ready), 64'd1);
    pos(); ib.instr_valid = 1'b0;
    neg(); pos();

    chk("a_queue_drained", 64'(qa.size()), 64'd0);
    chk("b_queue_drained", 64'(qb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
